// File: rtl/if_stage.sv
// if_stage - instruction-fetch stage of the MIPS pipeline.
//   Owns the PC, addresses a combinational 128x32 instruction memory and
//   captures {instruction, PC+4} into the IF/ID register. Decode can stall
//   the stage or redirect it with a taken beq or a j. When the PC leaves the
//   populated instruction space, fetch enters a sticky HALT state.
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   stall               hold PC and IF/ID (load-use hazard)
//   branch_taken/_imm   taken beq in ID and its 16-bit immediate
//   jump/jump_index     j in ID and its 26-bit target field
//   im_addr/im_data     instruction memory word address / returned word
//   pc                  current fetch PC
//   ifid_*              IF/ID register: instr, PC+4, valid
//   halted              fetch has stopped
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IM_DEPTH = 128,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [6:0]  im_addr,
  input  logic [31:0] im_data,
  output logic [31:0] pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic        halted
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t      state_q;
  logic [31:0] pc_q, instr_q, pp4_q;
  logic        valid_q, halted_q;

  logic [31:0] br_tgt, jp_tgt, pc_plus4;
  logic        in_range;

  assign pc_plus4 = pc_q + 32'd4;
  // Targets are relative to the instruction sitting in ID, i.e. its PC+4.
  assign br_tgt   = pp4_q + {{14{branch_imm[15]}}, branch_imm, 2'b00};
  assign jp_tgt   = {pp4_q[31:28], jump_index, 2'b00};
  assign in_range = (pc_q[1:0] == 2'b00) && (pc_q[31:2] < 30'(IM_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_WORD;
      pp4_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          // Redirects only count when ID holds a real instruction, and they
          // override stall; the sequentially fetched word is discarded.
          if (valid_q && jump) begin
            pc_q    <= jp_tgt;
            instr_q <= NOP_WORD;
            pp4_q   <= '0;
            valid_q <= 1'b0;
          end else if (valid_q && branch_taken) begin
            pc_q    <= br_tgt;
            instr_q <= NOP_WORD;
            pp4_q   <= '0;
            valid_q <= 1'b0;
          end else if (stall) begin
            // hold everything
          end else if (!in_range) begin
            instr_q  <= NOP_WORD;
            pp4_q    <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b1;
            state_q  <= HALT;
          end else begin
            instr_q <= im_data;
            pp4_q   <= pc_plus4;
            valid_q <= 1'b1;
            pc_q    <= pc_plus4;
          end
        end
        default: begin
          // Sticky until reset; ID only ever holds a bubble here.
          instr_q  <= NOP_WORD;
          pp4_q    <= '0;
          valid_q  <= 1'b0;
          halted_q <= 1'b1;
        end
      endcase
    end
  end

  assign im_addr       = pc_q[8:2];
  assign pc            = pc_q;
  assign ifid_instr    = instr_q;
  assign ifid_pc_plus4 = pp4_q;
  assign ifid_valid    = valid_q;
  assign halted        = halted_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a table of one-cycle vectors from reset, plus
// hand-written sequences for free-run halt and asynchronous reset.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branch_taken, jump;
  logic [15:0] branch_imm;
  logic [25:0] jump_index;
  logic [6:0]  im_addr;
  logic [31:0] im_data, pc, ifid_instr, ifid_pc_plus4;
  logic        ifid_valid, halted;

  logic [31:0] mem [128];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign im_data = mem[im_addr];

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_imm(branch_imm), .jump(jump), .jump_index(jump_index),
    .im_addr(im_addr), .im_data(im_data), .pc(pc), .ifid_instr(ifid_instr),
    .ifid_pc_plus4(ifid_pc_plus4), .ifid_valid(ifid_valid), .halted(halted)
  );

  typedef struct {
    logic        st, br;
    logic [15:0] imm;
    logic        jp;
    logic [25:0] ji;
    logic [31:0] pc, instr, pp4;
    logic        v, h;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic st, logic br, logic [15:0] imm, logic jp,
                              logic [25:0] ji, logic [31:0] epc,
                              logic [31:0] ein, logic [31:0] epp4,
                              logic ev, logic eh);
    vec_t r;
    r.st = st; r.br = br; r.imm = imm; r.jp = jp; r.ji = ji;
    r.pc = epc; r.instr = ein; r.pp4 = epp4; r.v = ev; r.h = eh;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(string tag, logic [31:0] epc, logic [31:0] ein,
                         logic [31:0] epp4, logic ev, logic eh);
    logic [31:0] a;
    a = epc;
    chk({tag, " pc"}, pc, epc);
    chk({tag, " im_addr"}, {25'd0, im_addr}, {25'd0, a[8:2]});
    chk({tag, " instr"}, ifid_instr, ein);
    chk({tag, " pp4"}, ifid_pc_plus4, epp4);
    chk({tag, " valid"}, {31'd0, ifid_valid}, {31'd0, ev});
    chk({tag, " halted"}, {31'd0, halted}, {31'd0, eh});
  endtask

  task automatic idle_inputs();
    stall = 0; branch_taken = 0; branch_imm = '0; jump = 0; jump_index = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 128; i++)
      mem[i] = (i == 0) ? 32'h8C10_0000 : (i == 1) ? 32'h8C11_0004 :
               (i < 21) ? 32'h2000_0000 + i : 32'h0;

    // Each row: inputs during the cycle, expected state after the edge.
    tv.push_back(mk(0,0,16'h0,0,0, 32'h04, mem[0], 32'h04, 1,0));
    tv.push_back(mk(0,0,16'h0,0,0, 32'h08, mem[1], 32'h08, 1,0));
    tv.push_back(mk(1,0,16'h0,0,0, 32'h08, mem[1], 32'h08, 1,0));
    tv.push_back(mk(1,0,16'h0,0,0, 32'h08, mem[1], 32'h08, 1,0));
    tv.push_back(mk(0,0,16'h0,0,0, 32'h0C, mem[2], 32'h0C, 1,0));
    tv.push_back(mk(0,0,16'h0,0,0, 32'h10, mem[3], 32'h10, 1,0));
    tv.push_back(mk(0,0,16'h0,0,0, 32'h14, mem[4], 32'h14, 1,0));
    tv.push_back(mk(0,0,16'h0,0,0, 32'h18, mem[5], 32'h18, 1,0));
    tv.push_back(mk(0,0,16'h0,0,0, 32'h1C, mem[6], 32'h1C, 1,0));
    tv.push_back(mk(0,0,16'h0,0,0, 32'h20, mem[7], 32'h20, 1,0));
    tv.push_back(mk(0,1,16'h0001,0,0, 32'h24, 32'h0, 32'h0, 0,0));    // beq +1
    tv.push_back(mk(0,0,16'h0,1,7, 32'h28, mem[9], 32'h28, 1,0));     // j on bubble ignored
    tv.push_back(mk(0,0,16'h0,1,7, 32'h1C, 32'h0, 32'h0, 0,0));       // j 7
    tv.push_back(mk(0,0,16'h0,0,0, 32'h20, mem[7], 32'h20, 1,0));
    tv.push_back(mk(0,1,16'hFFFF,0,0, 32'h1C, 32'h0, 32'h0, 0,0));    // beq -1
    tv.push_back(mk(0,1,16'h0001,0,0, 32'h20, mem[7], 32'h20, 1,0));  // beq on bubble ignored
    tv.push_back(mk(0,0,16'h0,1,13, 32'h34, 32'h0, 32'h0, 0,0));      // j 13
    tv.push_back(mk(0,0,16'h0,0,0, 32'h38, mem[13], 32'h38, 1,0));
    tv.push_back(mk(1,1,16'h0001,1,3, 32'h0C, 32'h0, 32'h0, 0,0));    // j beats beq and stall
    tv.push_back(mk(1,0,16'h0,0,0, 32'h0C, 32'h0, 32'h0, 0,0));       // stall holds bubble
    tv.push_back(mk(0,0,16'h0,0,0, 32'h10, mem[3], 32'h10, 1,0));
    tv.push_back(mk(1,1,16'h0001,0,0, 32'h14, 32'h0, 32'h0, 0,0));    // beq beats stall
    tv.push_back(mk(0,0,16'h0,0,0, 32'h18, mem[5], 32'h18, 1,0));
    tv.push_back(mk(0,0,16'h0,1,200, 32'h320, 32'h0, 32'h0, 0,0));    // out-of-range target
    tv.push_back(mk(0,0,16'h0,0,0, 32'h320, 32'h0, 32'h0, 0,1));      // halt on next edge
    tv.push_back(mk(1,0,16'h0,0,0, 32'h320, 32'h0, 32'h0, 0,1));
    tv.push_back(mk(1,1,16'h0001,1,1, 32'h320, 32'h0, 32'h0, 0,1));

    // Reset state, no clock edge needed
    idle_inputs();
    rst_n = 0;
    #2;
    chk_all("reset", 32'h0, 32'h0, 32'h0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1;
    chk_all("post-release", 32'h0, 32'h0, 32'h0, 0, 0);

    foreach (tv[i]) begin
      stall = tv[i].st; branch_taken = tv[i].br; branch_imm = tv[i].imm;
      jump = tv[i].jp; jump_index = tv[i].ji;
      tick();
      chk_all($sformatf("vec%0d", i), tv[i].pc, tv[i].instr, tv[i].pp4,
              tv[i].v, tv[i].h);
    end
    idle_inputs();

    // Free-run to the end of instruction space, then sticky halt
    rst_n = 0; #1; rst_n = 1;
    for (int k = 1; k <= 128; k++) tick();
    chk_all("free-run end", 32'h200, mem[127], 32'h200, 1, 0);
    tick();
    chk_all("free-run halt", 32'h200, 32'h0, 32'h0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      stall = k[0]; branch_taken = 1; branch_imm = 16'h0001;
      tick();
      chk_all($sformatf("halt hold%0d", k), 32'h200, 32'h0, 32'h0, 0, 1);
    end
    idle_inputs();

    // Async reset mid-cycle at pc=0x14
    rst_n = 0; #1; rst_n = 1;
    for (int k = 0; k < 5; k++) tick();
    chk_all("pre-async", 32'h14, mem[4], 32'h14, 1, 0);
    #2;
    rst_n = 0;
    #1;
    chk_all("async reset", 32'h0, 32'h0, 32'h0, 0, 0);
    @(negedge clk);
    rst_n = 1;
    tick();
    chk_all("restart e1", 32'h04, 32'h8C10_0000, 32'h04, 1, 0);
    tick();
    chk_all("restart e2", 32'h08, 32'h8C11_0004, 32'h08, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
